message_seq_rom: RTL

Parametrised multi-message text source for the UART debug path. Stores `MSG_COUNT` fixed-length-bounded ASCII messages in a synchronous ROM and, on a start pulse, streams the selected message byte by byte to the UART transmitter over a valid/ready handshake. Optional repeat mode and abort are supported. It sits between the status/command logic, which picks the message, and the UART TX serialiser.

---
 rtl/msg_rom_pkg.sv | 62 ++++++
 rtl/message_seq_rom_if.sv | 18 +
 rtl/msg_rom_store.sv | 34 +++
 rtl/message_seq_rom.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/msg_rom_pkg.sv
// ----------------------------------------------------------------------------
// msg_rom_pkg
// Shared definitions for the UART debug message source: sequencer state
// encoding, the pad character, the default message text and the per-message
// length table. Also provides helpers that map a flat ROM address to its
// stored character.
// ----------------------------------------------------------------------------
package msg_rom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [7:0] PAD_CHAR = 8'h20;

    localparam int DEF_MSG_COUNT = 3;
    localparam int DEF_MSG_LEN   = 4;

    // " 0\n\r", " 1\n\r", " X\n\r"
    localparam logic [7:0] MSG_DATA [DEF_MSG_COUNT*DEF_MSG_LEN] = '{
        8'h20, 8'h30, 8'h0A, 8'h0D,
        8'h20, 8'h31, 8'h0A, 8'h0D,
        8'h20, 8'h58, 8'h0A, 8'h0D
    };

    localparam int MSG_LENS [DEF_MSG_COUNT] = '{4, 4, 4};

    // Effective length of a message, clamped to 1..max_len. Messages beyond
    // the default table use the full slot.
    function automatic int msg_len_of(input int sel, input int max_len);
        int len;
        len = max_len;
        if (sel >= 0 && sel < DEF_MSG_COUNT) len = MSG_LENS[sel];
        if (len > max_len) len = max_len;
        if (len < 1) len = 1;
        return len;
    endfunction

    // True when the flat address falls on a stored (non-pad) character.
    function automatic logic slot_used(input int addr, input int max_len);
        int msg;
        int off;
        msg = addr / max_len;
        off = addr % max_len;
        return (msg < DEF_MSG_COUNT) && (off < DEF_MSG_LEN) &&
               (off < msg_len_of(msg, max_len));
    endfunction

    function automatic logic [7:0] slot_char(input int addr, input int max_len);
        int msg;
        int off;
        logic [7:0] ch;
        msg = addr / max_len;
        off = addr % max_len;
        ch  = 8'h00;
        if (slot_used(addr, max_len)) ch = MSG_DATA[msg*DEF_MSG_LEN + off];
        return ch;
    endfunction

endpackage

// File: rtl/message_seq_rom_if.sv
// ----------------------------------------------------------------------------
// message_seq_rom_if
// Byte stream handshake between the message source and the UART TX
// serialiser. A transfer occurs on a rising edge with tx_valid && tx_ready.
//   tx_data  : character being offered
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts the character
// ----------------------------------------------------------------------------
interface message_seq_rom_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/msg_rom_store.sv
// ----------------------------------------------------------------------------
// msg_rom_store
// Synchronous message ROM with a registered read (one cycle latency).
// Addresses outside the array, or past a message's length, return PAD_CHAR.
//   clk  : clock
//   addr : flat address, message*MSG_LEN + byte index
//   data : character registered from addr on the previous rising edge
// ----------------------------------------------------------------------------
module msg_rom_store #(
    parameter int               WIDTH    = 8,
    parameter int               MSG_LEN  = 4,
    parameter int               DEPTH    = 12,
    parameter int               ADDR_W   = 4,
    parameter logic [WIDTH-1:0] PAD_CHAR = WIDTH'(msg_rom_pkg::PAD_CHAR)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data
);
    import msg_rom_pkg::*;

    logic [WIDTH-1:0] r_data;

    // No reset: the sequencer only exposes this value while it is in SEND.
    always_ff @(posedge clk) begin
        if (int'(addr) < DEPTH && slot_used(int'(addr), MSG_LEN))
            r_data <= WIDTH'(slot_char(int'(addr), MSG_LEN));
        else
            r_data <= PAD_CHAR;
    end

    assign data = r_data;

endmodule

// File: rtl/message_seq_rom.sv
// ----------------------------------------------------------------------------
// message_seq_rom
// Streams one of MSG_COUNT stored ASCII messages to the UART TX serialiser.
// A start pulse in IDLE picks the message; each byte is fetched from the ROM
// (FETCH) and then offered until accepted (SEND). Optional repeat restarts the
// message at its end; abort returns to IDLE without a done pulse.
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   msg_sel   : message index, sampled with start
//   repeat_en : restart the message when its final byte transfers
//   abort     : end the current message, return to IDLE
//   tx        : byte stream master (tx_data / tx_valid / tx_ready)
//   busy      : high whenever not IDLE
//   done      : one-cycle pulse after the final byte of a non-repeated message
//   err       : one-cycle pulse after a start with msg_sel >= MSG_COUNT
// ----------------------------------------------------------------------------
module message_seq_rom #(
    parameter int               WIDTH     = 8,
    parameter int               MSG_COUNT = 3,
    parameter int               MSG_LEN   = 4,
    parameter logic [WIDTH-1:0] PAD_CHAR  = WIDTH'(msg_rom_pkg::PAD_CHAR),
    localparam int              SEL_W     = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] msg_sel,
    input  logic             repeat_en,
    input  logic             abort,
    message_seq_rom_if.master tx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import msg_rom_pkg::*;

    localparam int DEPTH  = MSG_COUNT * MSG_LEN;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic [IDX_W-1:0] w_last_idx;
    logic [31:0]      w_addr_full;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0] w_rom_data;
    logic             w_valid;
    logic             w_hs;

    assign w_last_idx  = IDX_W'(msg_len_of(int'(r_sel), MSG_LEN) - 1);
    assign w_addr_full = 32'(r_sel) * 32'(MSG_LEN) + 32'(r_idx);
    assign w_addr      = w_addr_full[ADDR_W-1:0];

    msg_rom_store #(
        .WIDTH    (WIDTH),
        .MSG_LEN  (MSG_LEN),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .PAD_CHAR (PAD_CHAR)
    ) u_rom (
        .clk  (clk),
        .addr (w_addr),
        .data (w_rom_data)
    );

    assign w_valid = (r_state == SEND);
    assign w_hs    = w_valid && tx.tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (int'(msg_sel) < MSG_COUNT) begin
                        w_sel_nxt   = msg_sel;
                        w_idx_nxt   = '0;
                        w_state_nxt = FETCH;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            FETCH: begin
                w_state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                // Abort wins over everything; a coincident handshake still
                // consumes the byte on the sink side.
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_hs) begin
                    if (r_idx != w_last_idx) begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = FETCH;
                    end else if (repeat_en) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = FETCH;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Data is forced to zero outside SEND so reset clears it immediately
    // without needing a reset on the ROM output register.
    assign tx.tx_valid = w_valid;
    assign tx.tx_data  = w_valid ? w_rom_data : '0;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign err         = r_err;

endmodule
